// File: rtl/ahb_rom_arbiter_if.sv
// Bus bundle for the boot-ROM arbiter: two core-side AHB-Lite ports (m0, m1)
// and the single ROM slave port (s). The slave modport is the arbiter's view.
// The master modport is the surrounding system: the cores and the ROM.
interface ahb_rom_arbiter_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
);
    logic [AHB_ADDR_WIDTH-1:0] m0_haddr;
    logic [1:0]                m0_htrans;
    logic                      m0_hwrite;
    logic [2:0]                m0_hsize;
    logic [AHB_DATA_WIDTH-1:0] m0_hwdata;
    logic [AHB_DATA_WIDTH-1:0] m0_hrdata;
    logic                      m0_hready;
    logic                      m0_hresp;

    logic [AHB_ADDR_WIDTH-1:0] m1_haddr;
    logic [1:0]                m1_htrans;
    logic                      m1_hwrite;
    logic [2:0]                m1_hsize;
    logic [AHB_DATA_WIDTH-1:0] m1_hwdata;
    logic [AHB_DATA_WIDTH-1:0] m1_hrdata;
    logic                      m1_hready;
    logic                      m1_hresp;

    logic                      s_hsel;
    logic [AHB_ADDR_WIDTH-1:0] s_haddr;
    logic [1:0]                s_htrans;
    logic                      s_hwrite;
    logic [2:0]                s_hsize;
    logic [AHB_DATA_WIDTH-1:0] s_hwdata;
    logic                      s_hready;
    logic [AHB_DATA_WIDTH-1:0] s_hrdata;
    logic                      s_hreadyout;
    logic                      s_hresp;

    modport slave (
        input  m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hwdata,
        output m0_hrdata, m0_hready, m0_hresp,
        input  m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hwdata,
        output m1_hrdata, m1_hready, m1_hresp,
        output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hwdata, s_hready,
        input  s_hrdata, s_hreadyout, s_hresp
    );

    modport master (
        output m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hwdata,
        input  m0_hrdata, m0_hready, m0_hresp,
        output m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hwdata,
        input  m1_hrdata, m1_hready, m1_hresp,
        input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hwdata, s_hready,
        output s_hrdata, s_hreadyout, s_hresp
    );
endinterface

// File: rtl/ahb_rom_arbiter.sv
// Two-master AHB-Lite arbiter in front of the boot ROM. A losing address
// phase is parked in a per-master pending register and replayed later. The
// slave address path is combinational, so an uncontended access has no added
// latency. Round-robin between m0 (fetch) and m1 (data/debug).
module ahb_rom_arbiter #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    ahb_rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Data-phase owner and round-robin history (last_r: 0 = m0, 1 = m1).
    owner_t                    owner_r;
    logic                      last_r;
    logic                      pend0_r, pend1_r;
    logic [AHB_ADDR_WIDTH-1:0] pend0_addr_r, pend1_addr_r;
    logic                      pend0_write_r, pend1_write_r;
    logic [2:0]                pend0_size_r, pend1_size_r;
    // Last address phase shown to the ROM; held while no grant is made.
    logic [AHB_ADDR_WIDTH-1:0] hold_addr_r;
    logic                      hold_write_r;
    logic [2:0]                hold_size_r;

    owner_t                    owner_s;
    logic                      pend0_s, pend1_s;
    logic                      m0_hready_s, m1_hready_s, s_hready_s;
    logic                      live0_s, live1_s, cand0_s, cand1_s;
    logic                      grant0_s, grant1_s;
    logic [AHB_ADDR_WIDTH-1:0] grant_addr_s;
    logic                      grant_write_s;
    logic [2:0]                grant_size_s;
    logic [AHB_DATA_WIDTH-1:0] s_hwdata_s, m0_hrdata_s, m1_hrdata_s;
    logic                      m0_hresp_s, m1_hresp_s;

    // Handshake and arbitration; reset masks the state so outputs show reset values at once.
    always_comb begin
        owner_s = owner_r;
        pend0_s = pend0_r;
        pend1_s = pend1_r;
        if (rst) begin
            owner_s = OWN_NONE;
            pend0_s = 1'b0;
            pend1_s = 1'b0;
        end else begin
            owner_s = owner_r;
        end
        m0_hready_s = (owner_s == OWN_M0) ? bus.s_hreadyout : ~pend0_s;
        m1_hready_s = (owner_s == OWN_M1) ? bus.s_hreadyout : ~pend1_s;
        s_hready_s  = (owner_s == OWN_NONE) ? 1'b1 : bus.s_hreadyout;
        live0_s = ((bus.m0_htrans == HTRANS_NONSEQ) || (bus.m0_htrans == HTRANS_SEQ)) & m0_hready_s;
        live1_s = ((bus.m1_htrans == HTRANS_NONSEQ) || (bus.m1_htrans == HTRANS_SEQ)) & m1_hready_s;
        cand0_s = pend0_s | live0_s;
        cand1_s = pend1_s | live1_s;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (s_hready_s && !rst) begin
            if (cand0_s && cand1_s) begin
                if (last_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (cand0_s) begin
                grant0_s = 1'b1;
            end else if (cand1_s) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
        end
    end

    // Slave address mux: a parked phase takes priority over the live bus of the same master.
    always_comb begin
        grant_addr_s  = hold_addr_r;
        grant_write_s = hold_write_r;
        grant_size_s  = hold_size_r;
        if (grant0_s) begin
            if (pend0_s) begin
                grant_addr_s  = pend0_addr_r;
                grant_write_s = pend0_write_r;
                grant_size_s  = pend0_size_r;
            end else begin
                grant_addr_s  = bus.m0_haddr;
                grant_write_s = bus.m0_hwrite;
                grant_size_s  = bus.m0_hsize;
            end
        end else if (grant1_s) begin
            if (pend1_s) begin
                grant_addr_s  = pend1_addr_r;
                grant_write_s = pend1_write_r;
                grant_size_s  = pend1_size_r;
            end else begin
                grant_addr_s  = bus.m1_haddr;
                grant_write_s = bus.m1_hwrite;
                grant_size_s  = bus.m1_hsize;
            end
        end else begin
            grant_addr_s = hold_addr_r;
        end
    end

    // Data-phase routing follows the current owner only.
    always_comb begin
        s_hwdata_s  = {AHB_DATA_WIDTH{1'b0}};
        m0_hrdata_s = {AHB_DATA_WIDTH{1'b0}};
        m1_hrdata_s = {AHB_DATA_WIDTH{1'b0}};
        m0_hresp_s  = 1'b0;
        m1_hresp_s  = 1'b0;
        case (owner_s)
            OWN_M0: begin
                s_hwdata_s  = bus.m0_hwdata;
                m0_hrdata_s = bus.s_hrdata;
                m0_hresp_s  = bus.s_hresp;
            end
            OWN_M1: begin
                s_hwdata_s  = bus.m1_hwdata;
                m1_hrdata_s = bus.s_hrdata;
                m1_hresp_s  = bus.s_hresp;
            end
            default: begin
                s_hwdata_s = {AHB_DATA_WIDTH{1'b0}};
            end
        endcase
    end

    assign bus.s_hsel    = grant0_s | grant1_s;
    assign bus.s_htrans  = (grant0_s | grant1_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.s_haddr   = grant_addr_s;
    assign bus.s_hwrite  = grant_write_s;
    assign bus.s_hsize   = grant_size_s;
    assign bus.s_hwdata  = s_hwdata_s;
    assign bus.s_hready  = s_hready_s;
    assign bus.m0_hready = m0_hready_s;
    assign bus.m1_hready = m1_hready_s;
    assign bus.m0_hrdata = m0_hrdata_s;
    assign bus.m1_hrdata = m1_hrdata_s;
    assign bus.m0_hresp  = m0_hresp_s;
    assign bus.m1_hresp  = m1_hresp_s;

    // Owner/round-robin update, capture of losing address phases, and slave address hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r       <= OWN_NONE;
            last_r        <= 1'b1;
            pend0_r       <= 1'b0;
            pend1_r       <= 1'b0;
            pend0_addr_r  <= {AHB_ADDR_WIDTH{1'b0}};
            pend1_addr_r  <= {AHB_ADDR_WIDTH{1'b0}};
            pend0_write_r <= 1'b0;
            pend1_write_r <= 1'b0;
            pend0_size_r  <= 3'b000;
            pend1_size_r  <= 3'b000;
            hold_addr_r   <= {AHB_ADDR_WIDTH{1'b0}};
            hold_write_r  <= 1'b0;
            hold_size_r   <= 3'b000;
        end else begin
            if (s_hready_s) begin
                if (grant0_s) begin
                    owner_r <= OWN_M0;
                    last_r  <= 1'b0;
                end else if (grant1_s) begin
                    owner_r <= OWN_M1;
                    last_r  <= 1'b1;
                end else begin
                    owner_r <= OWN_NONE;
                end
            end
            if (grant0_s) begin
                pend0_r <= 1'b0;
            end else if (live0_s) begin
                pend0_r       <= 1'b1;
                pend0_addr_r  <= bus.m0_haddr;
                pend0_write_r <= bus.m0_hwrite;
                pend0_size_r  <= bus.m0_hsize;
            end
            if (grant1_s) begin
                pend1_r <= 1'b0;
            end else if (live1_s) begin
                pend1_r       <= 1'b1;
                pend1_addr_r  <= bus.m1_haddr;
                pend1_write_r <= bus.m1_hwrite;
                pend1_size_r  <= bus.m1_hsize;
            end
            if (grant0_s || grant1_s) begin
                hold_addr_r  <= grant_addr_s;
                hold_write_r <= grant_write_s;
                hold_size_r  <= grant_size_s;
            end
        end
    end
endmodule

// File: tb/tb_ahb_rom_arbiter.sv
// Bench for ahb_rom_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based transaction model.
module tb_ahb_rom_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
        logic [2:0]    size;
    } aphase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ahb_rom_arbiter_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) bus ();

    ahb_rom_arbiter #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: who is in the data phase, who won last, parked phases per master,
    // and per-master scoreboards of accepted address phases awaiting issue to the ROM.
    int      mdl_own = -1;
    int      mdl_last = 1;
    aphase_t mdl_hold = '0;
    aphase_t parked [2][$];
    aphase_t accepted [2][$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic [1:0] t0, input logic [31:0] a0,
                              input logic [1:0] t1, input logic [31:0] a1,
                              input logic rdyo, input logic [31:0] rdata);
        bus.m0_htrans = t0; bus.m0_haddr = a0; bus.m0_hwrite = 1'b0; bus.m0_hsize = 3'b010;
        bus.m1_htrans = t1; bus.m1_haddr = a1; bus.m1_hwrite = 1'b0; bus.m1_hsize = 3'b010;
        bus.m0_hwdata = 32'h0; bus.m1_hwdata = 32'h0;
        bus.s_hreadyout = rdyo; bus.s_hrdata = rdata; bus.s_hresp = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One cycle of the reference: evaluated mid-cycle when inputs are stable; the state it
    // leaves behind is what should hold after the next rising edge.
    task automatic model_step();
        aphase_t live [2];
        aphase_t gph;
        aphase_t exp_ph;
        logic [1:0] tr [2];
        bit rdy [2];
        bit req [2];
        bit has [2];
        bit srdy;
        int win;
        logic [DW-1:0] exp_wdata;
        live[0] = '{bus.m0_haddr, bus.m0_hwrite, bus.m0_hsize};
        live[1] = '{bus.m1_haddr, bus.m1_hwrite, bus.m1_hsize};
        tr[0] = bus.m0_htrans;
        tr[1] = bus.m1_htrans;
        if (rst) begin
            check_val("rst_m0_hready", bus.m0_hready, 1);
            check_val("rst_m1_hready", bus.m1_hready, 1);
            check_val("rst_s_hsel", bus.s_hsel, 0);
            check_val("rst_s_htrans", bus.s_htrans, 0);
            check_val("rst_s_hready", bus.s_hready, 1);
            check_val("rst_m0_hrdata", bus.m0_hrdata, 0);
            check_val("rst_m1_hrdata", bus.m1_hrdata, 0);
            check_val("rst_m0_hresp", bus.m0_hresp, 0);
            check_val("rst_m1_hresp", bus.m1_hresp, 0);
            mdl_own = -1;
            mdl_last = 1;
            mdl_hold = '0;
            for (int i = 0; i < 2; i++) begin
                parked[i].delete();
                accepted[i].delete();
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            rdy[i] = (mdl_own == i) ? bus.s_hreadyout : (parked[i].size() == 0);
        end
        srdy = (mdl_own < 0) ? 1'b1 : bus.s_hreadyout;
        for (int i = 0; i < 2; i++) begin
            req[i] = tr[i][1] && rdy[i];
            has[i] = (parked[i].size() > 0) || req[i];
            if (req[i]) accepted[i].push_back(live[i]);
        end
        win = -1;
        if (srdy) begin
            if (has[0] && has[1]) win = 1 - mdl_last;
            else if (has[0]) win = 0;
            else if (has[1]) win = 1;
        end
        if (win >= 0) gph = (parked[win].size() > 0) ? parked[win][0] : live[win];
        else gph = mdl_hold;
        exp_wdata = (mdl_own == 0) ? bus.m0_hwdata : (mdl_own == 1) ? bus.m1_hwdata : '0;

        check_val("m0_hready", bus.m0_hready, rdy[0]);
        check_val("m1_hready", bus.m1_hready, rdy[1]);
        check_val("s_hready", bus.s_hready, srdy);
        check_val("s_hsel", bus.s_hsel, win >= 0);
        check_val("s_htrans", bus.s_htrans, (win >= 0) ? 2 : 0);
        check_val("s_haddr", bus.s_haddr, gph.addr);
        check_val("s_hwrite", bus.s_hwrite, gph.write);
        check_val("s_hsize", bus.s_hsize, gph.size);
        check_val("s_hwdata", bus.s_hwdata, exp_wdata);
        check_val("m0_hrdata", bus.m0_hrdata, (mdl_own == 0) ? bus.s_hrdata : 0);
        check_val("m1_hrdata", bus.m1_hrdata, (mdl_own == 1) ? bus.s_hrdata : 0);
        check_val("m0_hresp", bus.m0_hresp, (mdl_own == 0) ? bus.s_hresp : 0);
        check_val("m1_hresp", bus.m1_hresp, (mdl_own == 1) ? bus.s_hresp : 0);

        if (win >= 0) begin
            if (accepted[win].size() == 0) begin
                check_val("sb_issue_unaccepted", 1, 0);
            end else begin
                exp_ph = accepted[win].pop_front();
                check_val("sb_order", bus.s_haddr, exp_ph.addr);
            end
            if (parked[win].size() > 0) void'(parked[win].pop_front());
            mdl_hold = gph;
            mdl_last = win;
        end
        for (int i = 0; i < 2; i++) begin
            if (req[i] && i != win) parked[i].push_back(live[i]);
        end
        if (srdy) mdl_own = win;
    endtask

    initial begin
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'h0);
        fork
            forever begin
                @(negedge clk);
                model_step();
            end
        join_none

        // Reset held for two cycles, then idle bus.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("idle_m0_hready", bus.m0_hready, 1);
        check_val("idle_s_hsel", bus.s_hsel, 0);

        // Single uncontended m0 read.
        @(posedge clk); #1;
        set_inputs(2'b10, 32'h0000_0010, 2'b00, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        check_val("single_addr", bus.s_haddr, 32'h10);
        check_val("single_sel", bus.s_hsel, 1);
        check_val("single_m1_rdy", bus.m1_hready, 1);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'hCAFE_0010);
        @(negedge clk);
        check_val("single_m0_rdy", bus.m0_hready, 1);
        check_val("single_rdata", bus.m0_hrdata, 32'hCAFE_0010);
        check_val("single_m1_rdata", bus.m1_hrdata, 0);

        // Simultaneous m0/m1 after reset: m0 first, m1 replayed next cycle.
        pulse_reset();
        @(posedge clk); #1;
        set_inputs(2'b10, 32'h20, 2'b10, 32'h40, 1'b1, 32'h0);
        @(negedge clk);
        check_val("tie_c0_addr", bus.s_haddr, 32'h20);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        check_val("tie_c1_addr", bus.s_haddr, 32'h40);
        check_val("tie_c1_m1_rdy", bus.m1_hready, 0);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'hBEEF_0040);
        @(negedge clk);
        check_val("tie_c2_m1_rdy", bus.m1_hready, 1);
        check_val("tie_c2_m1_rdata", bus.m1_hrdata, 32'hBEEF_0040);

        // Both masters requesting every cycle: strict alternation.
        pulse_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            set_inputs(2'b10, 32'h1000 + k, 2'b10, 32'h2000 + k, 1'b1, 32'h0);
            @(negedge clk);
            check_val("alt_owner", bus.s_haddr[15:12], (k % 2 == 0) ? 1 : 2);
            check_val("alt_some_ready", bus.m0_hready | bus.m1_hready, 1);
        end

        // Two ROM wait states on an m0 read while m1 issues 0x44.
        pulse_reset();
        @(posedge clk); #1;
        set_inputs(2'b10, 32'h80, 2'b00, 32'h0, 1'b1, 32'h0);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b10, 32'h44, 1'b0, 32'h0);
        @(negedge clk);
        check_val("ws1_sel", bus.s_hsel, 0);
        check_val("ws1_m0_rdy", bus.m0_hready, 0);
        check_val("ws1_m1_rdy", bus.m1_hready, 1);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        check_val("ws2_sel", bus.s_hsel, 0);
        check_val("ws2_m1_rdy", bus.m1_hready, 0);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        check_val("ws3_sel", bus.s_hsel, 1);
        check_val("ws3_addr", bus.s_haddr, 32'h44);
        check_val("ws3_m0_rdy", bus.m0_hready, 1);

        // Reset with m1 parked and m0 owning a stalled data phase: no replay afterwards.
        pulse_reset();
        @(posedge clk); #1;
        set_inputs(2'b10, 32'h80, 2'b00, 32'h0, 1'b1, 32'h0);
        @(posedge clk); #1;
        set_inputs(2'b00, 32'h0, 2'b10, 32'h44, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        check_val("rstmid_htrans", bus.s_htrans, 0);
        check_val("rstmid_m0_rdy", bus.m0_hready, 1);
        check_val("rstmid_m1_rdy", bus.m1_hready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rstmid_no_replay", bus.s_hsel, 0);

        // Random traffic, including ROM stalls, error responses and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 199) == 0);
            bus.m0_htrans   = 2'($urandom_range(0, 3));
            bus.m1_htrans   = 2'($urandom_range(0, 3));
            bus.m0_haddr    = $urandom & 32'h0000_FFFC;
            bus.m1_haddr    = $urandom & 32'h0000_FFFC;
            bus.m0_hwrite   = 1'($urandom_range(0, 1));
            bus.m1_hwrite   = 1'($urandom_range(0, 1));
            bus.m0_hsize    = 3'($urandom_range(0, 2));
            bus.m1_hsize    = 3'($urandom_range(0, 2));
            bus.m0_hwdata   = $urandom;
            bus.m1_hwdata   = $urandom;
            bus.s_hrdata    = $urandom;
            bus.s_hreadyout = ($urandom_range(0, 3) != 0);
            bus.s_hresp     = ($urandom_range(0, 9) == 0);
        end

        // Drain: every accepted phase must have reached the ROM.
        @(posedge clk); #1;
        rst = 1'b0;
        set_inputs(2'b00, 32'h0, 2'b00, 32'h0, 1'b1, 32'h0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        check_val("drain_m0_left", accepted[0].size(), 0);
        check_val("drain_m1_left", accepted[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
